countdown_multi: RTL and testbench
==================================

# countdown_multi

Parametrised multi-channel countdown timer, the next generation of the single-channel second countdown in the digital-clock design. Each of CHANNELS independent channels loads a target second count, counts down one unit per TICK_DIV clock cycles while running, and supports pause/resume, clear, a sticky expiry flag with acknowledge, and optional auto-reload. It sits between the button/switch front end and the seven-segment display and buzzer logic.

## Interface
- CHANNELS, 4, number of independent countdown channels (≥1)
- SEC_W, 17, width of per-channel second count
- TICK_DIV, 100_000_000, clock cycles per count unit (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  CHANNELS  per-channel: latch target into count and reload register
- tar_sec  in  CHANNELS*SEC_W  per-channel target, channel i at [i*SEC_W +: SEC_W]
- run  in  CHANNELS  per-channel start/resume request
- pause  in  CHANNELS  per-channel pause request
- clear  in  CHANNELS  per-channel clear
- ack  in  CHANNELS  per-channel expiry acknowledge
- mode  in  CHANNELS  per-channel 1 = auto-reload, 0 = one-shot
- seconds  out  CHANNELS*SEC_W  current count, same packing as tar_sec
- busy  out  CHANNELS  channel in RUN
- done  out  CHANNELS  sticky expiry flag (drives per-channel buzzer)
- expire  out  CHANNELS  one-cycle pulse when count reaches 0
- buzzer  out  1  OR of done

## Operation
- Per-channel states: IDLE, RUN, PAUSE, DONE. Per-channel prescaler pre (0..TICK_DIV-1), count, reload register.
- Per-channel priority per cycle: rst > clear > load > ack > run/pause > tick.
- rst: all channels IDLE, count=0, reload=0, pre=0, all outputs 0.
- clear: that channel IDLE, count=0, pre=0, done=0; reload unchanged.
- load: count=tar_sec, reload=tar_sec, pre=0, done=0, state IDLE (from any state, including RUN).
- ack: in DONE → IDLE, done=0; otherwise ignored. ack and run in the same cycle: ack wins, run ignored.
- run=1,pause=0: IDLE or PAUSE with count>0 → RUN. IDLE entry sets pre=0; PAUSE resume keeps pre. count=0 → request ignored, stays IDLE. In DONE ignored.
- run=0,pause=1: RUN → PAUSE, pre and count held. Elsewhere ignored.
- run=1,pause=1: no effect.
- RUN: pre increments each cycle; when pre==TICK_DIV-1, pre wraps to 0 and count decrements.
- Decrement 1→0: expire pulses that cycle. One-shot (or auto-reload compiled out): state DONE, done=1, busy=0. Auto-reload: count=reload, stays RUN, done not set; reload=0 → DONE as one-shot.
- Count never underflows; 0 never decrements.

## Timing
- All outputs registered; state/count changes are visible the cycle after the triggering input edge.
- run sampled at edge N → busy=1 after N; first decrement at edge N+TICK_DIV; subsequent every TICK_DIV cycles.
- Pause for any duration then resume: remaining fraction of the current unit preserved exactly.
- expire high exactly one cycle; done stays high until ack, clear, load or rst.
- Channels fully independent; no shared prescaler.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined: mode input honoured as above.
- Undefined: mode ignored, every channel one-shot; reload register still written by load (used only for value retention), no reload logic synthesised.

## Structure
- countdown_pkg: cd_state_t enum (IDLE, RUN, PAUSE, DONE), state encoding constants, function for prescaler width ($clog2(TICK_DIV)).
- Sub-module countdown_channel: one channel (FSM, prescaler, count, reload); countdown_multi generates CHANNELS instances, slices buses, ORs done into buzzer.

## Test plan (TICK_DIV=4, SEC_W=8, CHANNELS=2)
- rst, then load ch0 tar=3, run ch0 → seconds0 3,2,1,0 at 4,8,12 cycles after busy; expire pulse at last step; done0=1, buzzer=1, busy0=0.
- ch0 tar=5 running, pause after 6 cycles (count 4, pre 1), hold 20 cycles, resume → next decrement 3 cycles after resume.
- run with count=0 → busy stays 0, no expire; run+pause together in RUN → no state change.
- With COUNTDOWN_AUTORELOAD_EN, ch1 mode=1 tar=2 → count 2,1,2,1… with expire every 8 cycles, done1 never set; ch0 one-shot concurrently unaffected.
- done0=1: ack+run same cycle → IDLE, done0=0, busy0=0; clear mid-RUN → count 0, IDLE; load mid-RUN tar=9 → count 9, IDLE, pre=0.
- rst asserted mid-RUN on both channels → next cycle all outputs 0, all IDLE.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel state
// encoding and prescaler sizing helper.
package countdown_pkg;

    localparam logic [1:0] CD_ENC_IDLE  = 2'd0;
    localparam logic [1:0] CD_ENC_RUN   = 2'd1;
    localparam logic [1:0] CD_ENC_PAUSE = 2'd2;
    localparam logic [1:0] CD_ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = CD_ENC_IDLE,
        RUN   = CD_ENC_RUN,
        PAUSE = CD_ENC_PAUSE,
        DONE  = CD_ENC_DONE
    } cd_state_t;

    // Prescaler counts 0..div-1; keep at least one bit for the smallest divider.
    function automatic int pre_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: FSM, private prescaler, count and reload register.
// Auto-reload is built only when COUNTDOWN_AUTORELOAD_EN is defined.
module countdown_channel
    import countdown_pkg::*;
#(
    parameter int SEC_W    = 17,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEC_W-1:0] tar_sec,
    input  logic             run,
    input  logic             pause,
    input  logic             clear,
    input  logic             ack,
    input  logic             mode,
    output logic [SEC_W-1:0] seconds,
    output logic             busy,
    output logic             done,
    output logic             expire
);

    localparam int               PRE_W    = pre_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

    cd_state_t        state;
    logic [PRE_W-1:0] pre;
    logic [SEC_W-1:0] reload;

    wire start_req = run && !pause;
    wire pause_req = pause && !run;

`ifndef COUNTDOWN_AUTORELOAD_EN
    // Without auto-reload the mode input and reload value are never consulted.
    logic unused_cfg;
    assign unused_cfg = ^{mode, reload};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            seconds <= '0;
            reload  <= '0;
            pre     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            expire  <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                seconds <= '0;
                pre     <= '0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else if (load) begin
                state   <= IDLE;
                seconds <= tar_sec;
                reload  <= tar_sec;
                pre     <= '0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else if (ack && state == DONE) begin
                state <= IDLE;
                done  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_req && seconds != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            pre   <= '0;
                        end
                    end
                    // Resume keeps pre so the partial unit is not lost.
                    PAUSE: begin
                        if (start_req && seconds != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause_req) begin
                            state <= PAUSE;
                            busy  <= 1'b0;
                        end else if (pre == PRE_LAST) begin
                            pre <= '0;
                            if (seconds == SEC_ONE) begin
                                expire <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                if (mode && reload != '0) begin
                                    seconds <= reload;
                                end else begin
                                    seconds <= '0;
                                    state   <= DONE;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                end
`else
                                seconds <= '0;
                                state   <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
`endif
                            end else if (seconds != '0) begin
                                seconds <= seconds - SEC_ONE;
                            end
                        end else begin
                            pre <= pre + PRE_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/countdown_multi.sv
// CHANNELS independent countdown timers sharing only the clock; buzzer is the
// OR of all sticky done flags. Optional auto-reload: COUNTDOWN_AUTORELOAD_EN.
module countdown_multi
    import countdown_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEC_W    = 17,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*SEC_W-1:0] tar_sec,
    input  logic [CHANNELS-1:0]       run,
    input  logic [CHANNELS-1:0]       pause,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       ack,
    input  logic [CHANNELS-1:0]       mode,
    output logic [CHANNELS*SEC_W-1:0] seconds,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expire,
    output logic                      buzzer
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        countdown_channel #(
            .SEC_W    (SEC_W),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .tar_sec (tar_sec[i*SEC_W +: SEC_W]),
            .run     (run[i]),
            .pause   (pause[i]),
            .clear   (clear[i]),
            .ack     (ack[i]),
            .mode    (mode[i]),
            .seconds (seconds[i*SEC_W +: SEC_W]),
            .busy    (busy[i]),
            .done    (done[i]),
            .expire  (expire[i])
        );
    end

    assign buzzer = |done;

endmodule

// File: tb/tb_countdown_multi.sv
// Self-checking bench for countdown_multi (CHANNELS=2, SEC_W=8, TICK_DIV=4):
// per-cycle stimulus with expected outputs queued and checked after each edge.
module tb_countdown_multi;

    localparam int CH = 2;
    localparam int SW = 8;
    localparam int TD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    load, run, pause, clear, ack, mode;
    logic [CH*SW-1:0] tar_sec;
    logic [CH*SW-1:0] seconds;
    logic [CH-1:0]    busy, done, expire;
    logic             buzzer;

    countdown_multi #(
        .CHANNELS (CH),
        .SEC_W    (SW),
        .TICK_DIV (TD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .tar_sec (tar_sec),
        .run     (run),
        .pause   (pause),
        .clear   (clear),
        .ack     (ack),
        .mode    (mode),
        .seconds (seconds),
        .busy    (busy),
        .done    (done),
        .expire  (expire),
        .buzzer  (buzzer)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [1:0] load;
        logic [7:0] tar0;
        logic [7:0] tar1;
        logic [1:0] run;
        logic [1:0] pause;
        logic [1:0] clear;
        logic [1:0] ack;
        logic [1:0] mode;
    } stim_t;

    typedef struct packed {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [1:0] busy;
        logic [1:0] done;
        logic [1:0] expire;
        logic       buz;
    } exp_t;

    typedef struct {
        stim_t st;
        exp_t  ex;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic stim_t S(input logic r, input logic [1:0] ld, input logic [7:0] t0,
                                input logic [7:0] t1, input logic [1:0] rn, input logic [1:0] ps,
                                input logic [1:0] cl, input logic [1:0] ak, input logic [1:0] md);
        stim_t s;
        s.rst = r; s.load = ld; s.tar0 = t0; s.tar1 = t1; s.run = rn;
        s.pause = ps; s.clear = cl; s.ack = ak; s.mode = md;
        return s;
    endfunction

    function automatic exp_t E(input int s0, input int s1, input logic [1:0] b,
                               input logic [1:0] d, input logic [1:0] x);
        exp_t e;
        e.s0 = 8'(s0); e.s1 = 8'(s1); e.busy = b; e.done = d; e.expire = x;
        e.buz = |d;
        return e;
    endfunction

    function automatic stim_t IDLE_IN(input logic [1:0] md);
        return S(1'b0, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00, md);
    endfunction

    task automatic add(input stim_t st, input exp_t ex);
        vec_t v;
        v.st = st;
        v.ex = ex;
        tbl.push_back(v);
    endtask

    task automatic step(input stim_t st, input exp_t ex, input string name);
        exp_t want, got;
        @(negedge clk);
        rst = st.rst; load = st.load; tar_sec = {st.tar1, st.tar0}; run = st.run;
        pause = st.pause; clear = st.clear; ack = st.ack; mode = st.mode;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        got.s0 = seconds[7:0]; got.s1 = seconds[15:8]; got.busy = busy;
        got.done = done; got.expire = expire; got.buz = buzzer;
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got s0=%0d s1=%0d busy=%b done=%b expire=%b buzzer=%b, want s0=%0d s1=%0d busy=%b done=%b expire=%b buzzer=%b",
                     name, got.s0, got.s1, got.busy, got.done, got.expire, got.buz,
                     want.s0, want.s1, want.busy, want.done, want.expire, want.buz);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = '0; tar_sec = '0; run = '0; pause = '0;
        clear = '0; ack = '0; mode = '0;

        // Basic one-shot countdown of ch0 from 3, expiry, ack+run, run at zero.
        add(S(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00));
        add(S(0, 2'b01, 3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(3, 0, 2'b00, 2'b00, 2'b00));
        add(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), E(3, 0, 2'b01, 2'b00, 2'b00));
        for (int i = 1; i < 12; i++)
            add(IDLE_IN(2'b00), E(3 - i / TD, 0, 2'b01, 2'b00, 2'b00));
        add(IDLE_IN(2'b00), E(0, 0, 2'b00, 2'b01, 2'b01));
        add(IDLE_IN(2'b00), E(0, 0, 2'b00, 2'b01, 2'b00));
        add(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00));
        add(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00));
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].st, tbl[i].ex, $sformatf("tbl%0d", i));

        // Pause with a partial unit, hold, resume; run+pause together; clear; load.
        step(S(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00), "p_rst");
        step(S(0, 2'b01, 5, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(5, 0, 2'b00, 2'b00, 2'b00), "p_load");
        step(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), E(5, 0, 2'b01, 2'b00, 2'b00), "p_run");
        for (int i = 1; i <= 5; i++)
            step(IDLE_IN(2'b00), E(i < 4 ? 5 : 4, 0, 2'b01, 2'b00, 2'b00), $sformatf("p_cnt%0d", i));
        step(S(0, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00), E(4, 0, 2'b00, 2'b00, 2'b00), "p_pause");
        for (int i = 0; i < 20; i++)
            step(IDLE_IN(2'b00), E(4, 0, 2'b00, 2'b00, 2'b00), $sformatf("p_hold%0d", i));
        step(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), E(4, 0, 2'b01, 2'b00, 2'b00), "p_resume");
        step(IDLE_IN(2'b00), E(4, 0, 2'b01, 2'b00, 2'b00), "p_res1");
        step(IDLE_IN(2'b00), E(4, 0, 2'b01, 2'b00, 2'b00), "p_res2");
        step(IDLE_IN(2'b00), E(3, 0, 2'b01, 2'b00, 2'b00), "p_res3_dec");
        step(S(0, 2'b00, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00), E(3, 0, 2'b01, 2'b00, 2'b00), "rp_both");
        step(IDLE_IN(2'b00), E(3, 0, 2'b01, 2'b00, 2'b00), "rp_1");
        step(IDLE_IN(2'b00), E(3, 0, 2'b01, 2'b00, 2'b00), "rp_2");
        step(IDLE_IN(2'b00), E(2, 0, 2'b01, 2'b00, 2'b00), "rp_dec");
        step(S(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00), "clr_run");
        step(S(0, 2'b01, 6, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(6, 0, 2'b00, 2'b00, 2'b00), "l_load6");
        step(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), E(6, 0, 2'b01, 2'b00, 2'b00), "l_run");
        step(IDLE_IN(2'b00), E(6, 0, 2'b01, 2'b00, 2'b00), "l_w1");
        step(IDLE_IN(2'b00), E(6, 0, 2'b01, 2'b00, 2'b00), "l_w2");
        step(S(0, 2'b01, 9, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(9, 0, 2'b00, 2'b00, 2'b00), "l_load9");
        step(IDLE_IN(2'b00), E(9, 0, 2'b00, 2'b00, 2'b00), "l_idle");
        step(S(0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), E(9, 0, 2'b01, 2'b00, 2'b00), "l_rerun");
        for (int i = 1; i <= TD; i++)
            step(IDLE_IN(2'b00), E(i < TD ? 9 : 8, 0, 2'b01, 2'b00, 2'b00), $sformatf("l_cnt%0d", i));

        // Both channels concurrently: ch0 one-shot from 3, ch1 tar 2 with mode=1.
        step(S(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10), E(0, 0, 2'b00, 2'b00, 2'b00), "a_rst");
        step(S(0, 2'b11, 3, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10), E(3, 2, 2'b00, 2'b00, 2'b00), "a_load");
        step(S(0, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10), E(3, 2, 2'b11, 2'b00, 2'b00), "a_run");
        for (int c = 1; c <= 24; c++) begin
            int s0, s1;
            logic [1:0] b, d, x;
            s0   = (c < 12) ? 3 - c / TD : 0;
            b[0] = (c < 12);
            d[0] = (c >= 12);
            x[0] = (c == 12);
`ifdef COUNTDOWN_AUTORELOAD_EN
            s1   = ((c / TD) % 2 == 1) ? 1 : 2;
            b[1] = 1'b1;
            d[1] = 1'b0;
            x[1] = (c % (2 * TD) == 0);
`else
            s1   = (c < 8) ? 2 - c / TD : 0;
            b[1] = (c < 8);
            d[1] = (c >= 8);
            x[1] = (c == 8);
`endif
            step(IDLE_IN(2'b10), E(s0, s1, b, d, x), $sformatf("a_cyc%0d", c));
        end

        // Reset in the middle of a run on both channels.
        step(S(0, 2'b11, 7, 7, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(7, 7, 2'b00, 2'b00, 2'b00), "r_load");
        step(S(0, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00), E(7, 7, 2'b11, 2'b00, 2'b00), "r_run");
        step(IDLE_IN(2'b00), E(7, 7, 2'b11, 2'b00, 2'b00), "r_w1");
        step(IDLE_IN(2'b00), E(7, 7, 2'b11, 2'b00, 2'b00), "r_w2");
        step(S(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00), "r_rst");
        step(IDLE_IN(2'b00), E(0, 0, 2'b00, 2'b00, 2'b00), "r_after");
        step(S(0, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00), E(0, 0, 2'b00, 2'b00, 2'b00), "r_run_zero");
        step(IDLE_IN(2'b00), E(0, 0, 2'b00, 2'b00, 2'b00), "r_still_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
